// File: rtl/darwin_tx_pkg.sv
// darwin_tx_pkg: shared types and defaults for the darwin transmit handshake.
//   tx_state_e      - handshake FSM state encoding
//   DATA_W_DEF      - default word width sent to the chip
//   TIMEOUT_DEF     - default ack-edge timeout in clock cycles (legal 2..65535)
//   TX_COUNT_W      - width of the completed-word counter
//   tmo_cnt_width() - bits needed to count up to a given timeout
package darwin_tx_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 1023;
   localparam int TX_COUNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      REQ_HI = 3'd2,
      REQ_LO = 3'd3,
      ERR    = 3'd4
   } tx_state_e;

   function automatic int tmo_cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/darwin_tx_hs_timeout_cnt.sv
// tx_timeout_cnt: cycle counter guarding each ack edge of the handshake.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clr     - restart the count (asserted on the edge that enters a wait state)
//   en      - high for every cycle spent in a wait state
//   expired - the current edge is the TIMEOUT_CYCLES-th edge since the clear
module tx_timeout_cnt
   import darwin_tx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
   // The count holds k-1 just before the k-th edge after the clear, so the
   // deadline edge is the one where the count has reached TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/darwin_tx_hs.sv
// darwin_tx_hs: sends one upstream word at a time to the chip over a 4-phase
// req/ack handshake, with a per-edge timeout and a sticky error state.
//   clk, rst             - system clock, synchronous active-high reset
//   s_data/s_valid/s_ready - upstream word interface (accept on valid && ready)
//   ack_sync             - chip acknowledge, already synchronized
//   tx_data, tx_req      - word and request driven to the chip pads (flopped)
//   busy                 - FSM is not IDLE
//   tx_count             - completed words, wraps at 16 bits (flopped)
//   timeout_err          - sticky timeout flag (flopped)
//   err_clr              - leaves ERR once ack_sync is low
//
// state  | meaning
// IDLE   | waiting for an upstream word; ready only while ack_sync is low
// SETUP  | word latched on the pads, one cycle of data setup before request
// REQ_HI | waiting for ack_sync high; tx_req is raised one cycle after entry
// REQ_LO | request dropped, waiting for ack_sync low to complete the word
// ERR    | an ack edge timed out; waits for err_clr with ack_sync low
module darwin_tx_hs
   import darwin_tx_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  ack_sync,
   output logic [DATA_W-1:0]     tx_data,
   output logic                  tx_req,
   output logic                  busy,
   output logic [TX_COUNT_W-1:0] tx_count,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   tx_state_e state_q;
   tx_state_e state_d;

   logic load_data;
   logic word_done;
   logic req_d;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_expired;

   always_comb begin
      state_d   = state_q;
      load_data = 1'b0;
      word_done = 1'b0;
      tmo_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_valid && s_ready) begin
               state_d   = SETUP;
               load_data = 1'b1;
            end
         end
         SETUP: begin
            state_d = REQ_HI;
         end
         REQ_HI: begin
            tmo_en = 1'b1;
            // An ack on the deadline edge still counts as on time.
            if (ack_sync) begin
               state_d = REQ_LO;
            end else if (tmo_expired) begin
               state_d = ERR;
            end
         end
         REQ_LO: begin
            tmo_en = 1'b1;
            if (!ack_sync) begin
               state_d   = IDLE;
               word_done = 1'b1;
            end else if (tmo_expired) begin
               state_d = ERR;
            end
         end
         ERR: begin
            if (err_clr && !ack_sync) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request goes high on the second edge after SETUP entry and drops on the
   // same edge that samples the ack, so it is only high while waiting in REQ_HI.
   assign req_d   = (state_q == REQ_HI) && (state_d == REQ_HI);
   assign tmo_clr = ((state_d == REQ_HI) && (state_q != REQ_HI)) ||
                    ((state_d == REQ_LO) && (state_q != REQ_LO));

   tx_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tx_req      <= 1'b0;
         tx_data     <= '0;
         tx_count    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_req      <= req_d;
         timeout_err <= (state_d == ERR);
         if (load_data) begin
            tx_data <= s_data;
         end
         if (word_done) begin
            tx_count <= tx_count + TX_COUNT_W'(1);
         end
      end
   end

   assign s_ready = (state_q == IDLE) && !ack_sync;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_darwin_tx_hs.sv
// tb_darwin_tx_hs: self-checking bench for darwin_tx_hs with TIMEOUT_CYCLES=8.
// Words pushed into a scoreboard on acceptance are compared against tx_data
// when tx_req rises, and tx_data is checked stable while tx_req is high.
module tb_darwin_tx_hs;
   import darwin_tx_pkg::*;

   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          ack_sync;
   logic [DW-1:0] tx_data;
   logic          tx_req;
   logic          busy;
   logic [15:0]   tx_count;
   logic          timeout_err;
   logic          err_clr = 1'b0;

   always #5 clk = ~clk;

   darwin_tx_hs #(
      .DATA_W        (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .ack_sync   (ack_sync),
      .tx_data    (tx_data),
      .tx_req     (tx_req),
      .busy       (busy),
      .tx_count   (tx_count),
      .timeout_err(timeout_err),
      .err_clr    (err_clr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] cur_word = '0;
   logic          req_prev = 1'b0;

   // Chip model: ack echoes tx_req after ack_dly cycles when auto_ack is set.
   logic        auto_ack = 1'b0;
   logic        ack_man  = 1'b1;
   logic        ack_auto = 1'b0;
   int          ack_dly  = 1;
   logic [15:0] hist     = '0;

   assign ack_sync = auto_ack ? ack_auto : ack_man;

   always @(negedge clk) begin
      hist     <= {hist[14:0], tx_req};
      ack_auto <= (ack_dly == 1) ? tx_req : hist[ack_dly-2];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer and data-stability monitor.
   always @(negedge clk) begin
      if (rst) begin
         req_prev <= 1'b0;
      end else begin
         if (tx_req && !req_prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL req_without_word: tx_req rose with tx_data 0x%0h, expected no request at %0t",
                        tx_data, $time);
            end else begin
               n_tests--;
               chk("word_at_req", tx_data, exp_q[0]);
               cur_word <= exp_q.pop_front();
            end
         end else if (tx_req) begin
            chk("data_stable", tx_data, cur_word);
         end
         req_prev <= tx_req;
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic send(input logic [DW-1:0] d);
      bit ok;
      ok      = 1'b0;
      s_data  = d;
      s_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (s_ready) begin
            exp_q.push_back(d);
            ok = 1'b1;
         end
         step();
      end
      s_valid = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL accept_timeout: word 0x%0h not accepted, expected acceptance within 64 cycles", d);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64 && busy; i++) begin
         step();
      end
      chkb("idle_within_bound", busy, 1'b0);
   endtask

   task automatic set_auto(input int d);
      ack_dly  = d;
      auto_ack = 1'b1;
      repeat (17) @(negedge clk);
      #2;
   endtask

   typedef struct {
      logic [DW-1:0] data;
      int            dly;
      logic [15:0]   exp_count;
      logic          exp_err;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{data: 32'h1234_5678, dly: 2, exp_count: 16'd5, exp_err: 1'b0};
      vecs[1] = '{data: 32'hFFFF_FFFF, dly: 3, exp_count: 16'd6, exp_err: 1'b0};
      vecs[2] = '{data: 32'h0000_0000, dly: 5, exp_count: 16'd7, exp_err: 1'b0};
      // ack arrives on the 8th edge after entry: must beat the timeout
      vecs[3] = '{data: 32'hDEAD_BEEF, dly: 7, exp_count: 16'd8, exp_err: 1'b0};

      // Reset with ack stuck high: not ready until ack is seen low.
      repeat (2) @(negedge clk);
      #2;
      chkb("rst_ready_ack_hi", s_ready, 1'b0);
      rst = 1'b0;
      step();
      chkb("rst_ready_ack_hi_after", s_ready, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_tx_req", tx_req, 1'b0);
      chk("rst_tx_data", tx_data, 32'h0);
      chk("rst_tx_count", 32'(tx_count), 32'h0);
      chkb("rst_timeout_err", timeout_err, 1'b0);
      ack_man = 1'b0;
      step();
      chkb("ready_after_ack_lo", s_ready, 1'b1);

      // Basic transfer with a hand-driven ack.
      send(32'hA5A5_0001);
      chkb("basic_busy_e0", busy, 1'b1);
      chk("basic_tx_data_e0", tx_data, 32'hA5A5_0001);
      chkb("basic_req_e0", tx_req, 1'b0);
      step();
      chkb("basic_req_e1", tx_req, 1'b0);
      step();
      chkb("basic_req_e2", tx_req, 1'b1);
      step();
      chkb("basic_req_e3", tx_req, 1'b1);
      ack_man = 1'b1;
      step();
      chkb("basic_req_e4", tx_req, 1'b0);
      chkb("basic_busy_e4", busy, 1'b1);
      step();
      step();
      ack_man = 1'b0;
      chk("basic_count_e6", 32'(tx_count), 32'd0);
      chkb("basic_ready_e6", s_ready, 1'b0);
      step();
      chk("basic_count_e7", 32'(tx_count), 32'd1);
      chkb("basic_busy_e7", busy, 1'b0);
      chkb("basic_ready_e7", s_ready, 1'b1);

      // Back-to-back words with s_valid held and a 1-cycle ack echo.
      set_auto(1);
      send(32'h1111_0001);
      send(32'h2222_0002);
      send(32'h3333_0003);
      wait_idle();
      chk("b2b_count", 32'(tx_count), 32'd4);

      // Table of ack latencies, up to the timeout boundary.
      for (int i = 0; i < 4; i++) begin
         set_auto(vecs[i].dly);
         send(vecs[i].data);
         wait_idle();
         chk("vec_count", 32'(tx_count), 32'(vecs[i].exp_count));
         chkb("vec_err", timeout_err, vecs[i].exp_err);
      end

      // Timeout: ack never rises.
      auto_ack = 1'b0;
      ack_man  = 1'b0;
      step();
      send(32'h0BAD_F00D);
      repeat (8) step();
      chkb("tmo_err_e8", timeout_err, 1'b0);
      chkb("tmo_req_e8", tx_req, 1'b1);
      step();
      chkb("tmo_err_e9", timeout_err, 1'b1);
      chkb("tmo_req_e9", tx_req, 1'b0);
      chkb("tmo_ready_e9", s_ready, 1'b0);
      chkb("tmo_busy_e9", busy, 1'b1);
      // err_clr with ack stuck high must not leave ERR.
      ack_man = 1'b1;
      err_clr = 1'b1;
      repeat (3) step();
      chkb("err_stuck_ack_err", timeout_err, 1'b1);
      chkb("err_stuck_ack_busy", busy, 1'b1);
      ack_man = 1'b0;
      step();
      err_clr = 1'b0;
      chkb("err_clr_err", timeout_err, 1'b0);
      chkb("err_clr_busy", busy, 1'b0);
      chk("err_clr_count", 32'(tx_count), 32'd8);
      chkb("err_clr_ready", s_ready, 1'b1);

      // Reset in the middle of REQ_HI.
      send(32'h5555_AAAA);
      step();
      step();
      chkb("mid_req_hi", tx_req, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chkb("mid_rst_req", tx_req, 1'b0);
      chk("mid_rst_data", tx_data, 32'h0);
      chk("mid_rst_count", 32'(tx_count), 32'h0);
      chkb("mid_rst_err", timeout_err, 1'b0);
      chkb("mid_rst_busy", busy, 1'b0);
      chkb("mid_rst_ready", s_ready, 1'b1);

      // Counter wrap from 0xFFFF.
      set_auto(1);
      force dut.tx_count = 16'hFFFF;
      step();
      release dut.tx_count;
      send(32'h0F0F_0F0F);
      wait_idle();
      chk("wrap_count", 32'(tx_count), 32'h0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/darwin_tx_hs.md
DARWIN_TX_HS -- requirements
Module: darwin_tx_hs

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 32, width of one word sent to the chip.
  TIMEOUT_CYCLES, 1023, maximum wait for each ack edge before error; legal range 2..65535.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all logic on its rising edge.
  rst  input  1  reset, synchronous and active-high.
  s_data  input  DATA_W  upstream word.
  s_valid  input  1  upstream word valid.
  s_ready  output  1  block accepts s_data this cycle.
  ack_sync  input  1  chip acknowledge, already passed through the 3-stage synchronizer upstream of this block.
  tx_data  output  DATA_W  word driven to the chip pads.
  tx_req  output  1  4-phase request to the chip.
  busy  output  1  high whenever state is not IDLE.
  tx_count  output  16  number of completed words.
  timeout_err  output  1  sticky timeout flag.
  err_clr  input  1  clears the error condition.
REQ-003 All outputs except s_ready and busy SHALL be driven directly from flops.

Function
REQ-004 FSM states SHALL be IDLE, SETUP, REQ_HI, REQ_LO and ERR.
REQ-005 s_ready SHALL equal (state==IDLE) && !ack_sync.
REQ-006 IDLE: on s_valid && s_ready at edge E0, the block SHALL latch s_data into tx_data and go to SETUP.
REQ-007 SETUP SHALL last exactly one cycle, holding tx_data stable, then go to REQ_HI with tx_req=1 registered at edge E0+2.
REQ-008 REQ_HI: at the first edge sampling ack_sync=1, the block SHALL set tx_req=0 and go to REQ_LO.
REQ-009 REQ_LO: at the first edge sampling ack_sync=0, the block SHALL go to IDLE and increment tx_count, wrapping 0xFFFF->0x0000.
REQ-010 tx_data SHALL NOT change outside the IDLE->SETUP transition.
REQ-011 A timeout counter, ceil(log2(TIMEOUT_CYCLES+1)) bits wide, SHALL clear on every entry to REQ_HI or REQ_LO and increment each cycle spent in that state.
REQ-012 If the awaited ack level is not sampled by the TIMEOUT_CYCLES-th edge after state entry, the FSM SHALL go to ERR.
REQ-013 An ack arriving on that same edge SHALL take priority over the timeout.
REQ-014 ERR: tx_req=0, timeout_err=1, s_ready=0; tx_count SHALL NOT increment.
REQ-015 ERR SHALL exit to IDLE only at an edge where err_clr=1 and ack_sync=0; timeout_err SHALL clear on that same edge.
REQ-016 err_clr SHALL be ignored in all states other than ERR.
REQ-017 s_valid SHALL be ignored in every state other than IDLE; no word is dropped or duplicated.

Reset
REQ-018 rst=1 at an edge SHALL force IDLE, tx_req=0, tx_data=0, tx_count=0, timeout_err=0 and timeout counter=0, including mid-handshake; rst SHALL dominate all other inputs.
REQ-019 After reset, s_ready=1 only once ack_sync is sampled 0.

Structure
REQ-020 A shared package darwin_tx_pkg SHALL hold the state enum type, the DATA_W and TIMEOUT_CYCLES defaults, and the tx_count width constant (16).
REQ-021 The timeout counter SHALL be a sub-module tx_timeout_cnt (inputs clk, rst, clr, en; output expired); all other logic SHALL stay in darwin_tx_hs.

Verification (TIMEOUT_CYCLES=8)
REQ-022 Basic transfer: s_data=0xA5A5_0001 with s_valid accepted at E0; ack_sync rises at E0+4 and falls 3 cycles later -> tx_req high from E0+2 to E0+4, tx_count=1, s_ready high again the cycle after ack falls.
REQ-023 Back-to-back: s_valid held with 3 words; ack echoes tx_req after 1 cycle -> three distinct words delivered in order, tx_count=3, tx_data stable throughout each req phase.
REQ-024 Timeout: ack_sync held 0 after tx_req rises -> ERR after 8 cycles, tx_req=0, timeout_err=1; err_clr pulse -> IDLE, timeout_err=0, tx_count unchanged.
REQ-025 Boundary and priority: ack arrives exactly on the 8th edge -> no error. Stuck ack_sync=1 in ERR with err_clr=1 -> stays in ERR until ack_sync=0.
REQ-026 Reset mid-handshake in REQ_HI: rst=1 for one edge -> all outputs at reset values. Preload tx_count=0xFFFF and complete one word -> tx_count wraps to 0.
